// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 2**AW x DW two-port memory (async read, sync write) between two
//   requesters with round-robin arbitration, and adds a clear engine that
//   overwrites every address with CLR_VALUE, taking priority over both clients.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   clr_start             : request a full-memory clear (honoured in IDLE only)
//   clr_busy, clr_done    : sweep in progress / one-cycle pulse after last write
//   reqN, weN, addrN,
//   wdataN                : requester N access (held until granted)
//   gntN                  : combinational grant, access happens this cycle
//   rvalidN, rdataN       : registered read data, one cycle after a read grant
//   mem_ra, mem_wa,
//   mem_write, mem_d      : memory read address / write port
//   mem_q                 : memory async read data
module mem_port_arbiter #(
  parameter int AW = 9,
  parameter int DW = 20,
  parameter logic [DW-1:0] CLR_VALUE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_ra,
  output logic [AW-1:0] mem_wa,
  output logic          mem_write,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          last_grant_q, last_grant_d;   // 1 = requester 1 was granted last
  logic          clr_busy_q, clr_busy_d;
  logic          clr_done_q, clr_done_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    mem_write    = 1'b0;
    mem_ra       = '0;
    mem_wa       = '0;
    mem_d        = '0;
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    last_grant_d = last_grant_q;
    clr_busy_d   = clr_busy_q;
    clr_done_d   = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    // Reset holds the memory port quiet so nothing is written while it is high.
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
            // The start cycle itself is a dead cycle: no grants, no writes.
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
            clr_busy_d = 1'b1;
          end else begin
            // On a tie, whoever was not granted last wins.
            gnt0 = req0 && (!req1 || last_grant_q);
            gnt1 = req1 && (!req0 || !last_grant_q);
          end
        end
        ST_CLEAR: begin
          mem_write  = 1'b1;
          mem_wa     = clr_addr_q;
          mem_d      = CLR_VALUE;
          clr_addr_d = clr_addr_q + 1'b1;   // wraps to 0 after the last address
          if (clr_addr_q == {AW{1'b1}}) begin
            state_d    = ST_IDLE;
            clr_busy_d = 1'b0;
            clr_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (gnt0) begin
        last_grant_d = 1'b0;
        if (we0) begin
          mem_write = 1'b1;
          mem_wa    = addr0;
          mem_d     = wdata0;
        end else begin
          mem_ra    = addr0;
          rvalid0_d = 1'b1;
          rdata0_d  = mem_q;
        end
      end

      if (gnt1) begin
        last_grant_d = 1'b1;
        if (we1) begin
          mem_write = 1'b1;
          mem_wa    = addr1;
          mem_d     = wdata1;
        end else begin
          mem_ra    = addr1;
          rvalid1_d = 1'b1;
          rdata1_d  = mem_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= '0;
      last_grant_q <= 1'b1;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      last_grant_q <= last_grant_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vectors, expected read data pushed
// into per-requester queues at grant time and popped by a monitor on rvalid.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clr_start = 1'b0;
  logic          clr_busy, clr_done;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_ra, mem_wa;
  logic          mem_write;
  logic [DW-1:0] mem_d, mem_q;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] exp0, exp1;

  // External 512x20 memory: async read, sync write.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  always @(posedge clk) if (mem_write) mem[mem_wa] <= mem_d;
  assign mem_q = mem[mem_ra];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .CLR_VALUE('0)) dut (
    .clk(clk), .reset(reset), .clr_start(clr_start),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_write(mem_write),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: pops expected read data whenever the DUT presents rvalid.
  always @(negedge clk) begin
    if (rvalid0 && rvalid1) check("rvalid_exclusive", 32'd1, 32'd0);
    if (rvalid0) begin
      if (q0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
      else begin
        exp0 = q0.pop_front();
        check("rdata0", {12'd0, rdata0}, {12'd0, exp0});
      end
    end
    if (rvalid1) begin
      if (q1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
      else begin
        exp1 = q1.pop_front();
        check("rdata1", {12'd0, rdata1}, {12'd0, exp1});
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One access by requester n; waits (bounded) for its grant, pushes the
  // expected read data, then drops the request after the grant edge.
  task automatic single(input int n, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] e);
    int waited;
    logic g;
    waited = 0;
    if (n == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    #1;
    g = (n == 0) ? gnt0 : gnt1;
    while (!g && waited < 600) begin
      tick; #1;
      waited++;
      g = (n == 0) ? gnt0 : gnt1;
    end
    if (!g) check("grant_timeout", 32'd0, 32'd1);
    else if (!we) begin
      if (n == 0) q0.push_back(e); else q1.push_back(e);
    end
    tick;
    if (n == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  // Called at the check point of the first CLEAR cycle; returns at the check
  // point of the first cycle after the sweep. Optionally re-pulses clr_start.
  task automatic watch_clear(input int restart_at, output int busy_cycles,
                             output int done_pulses, output int grants_busy,
                             output bit addr_ok);
    int  busy;
    bit  fin;
    logic [31:0] busy_v;
    busy = 0; fin = 0; addr_ok = 1; grants_busy = 0; done_pulses = 0;
    for (int i = 0; i < 1000 && !fin; i++) begin
      if (clr_busy) begin
        busy_v = busy;
        if (mem_wa !== busy_v[AW-1:0] || mem_write !== 1'b1 || mem_d !== '0) addr_ok = 0;
        if (gnt0 || gnt1) grants_busy++;
        if (clr_done) done_pulses++;
        busy++;
        @(posedge clk); #1;
        clr_start = (restart_at > 0 && busy == restart_at);
        #1;
      end else begin
        if (clr_done) done_pulses++;
        fin = 1;
      end
    end
    if (!fin) check("clear_timeout", 32'd0, 32'd1);
    clr_start = 1'b0;
    busy_cycles = busy;
  endtask

  int  bc, dp, gb;
  bit  aok;
  bit  seen;

  initial begin
    // ---------------- reset ----------------
    reset = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 9'd3; wdata0 = 20'h11111;
    tick; tick; #1;
    check("reset_gnt0", {31'd0, gnt0}, 32'd0);
    check("reset_mem_write", {31'd0, mem_write}, 32'd0);
    check("reset_rvalid0", {31'd0, rvalid0}, 32'd0);
    check("reset_rdata0", {12'd0, rdata0}, 32'd0);
    check("reset_clr_busy", {31'd0, clr_busy}, 32'd0);
    check("reset_clr_done", {31'd0, clr_done}, 32'd0);
    tick;
    reset = 1'b0; req0 = 1'b0;

    // ---------------- write then read back ----------------
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'd5; wdata0 = 20'hABCDE;
    #1;
    check("wr_gnt0", {31'd0, gnt0}, 32'd1);
    check("wr_mem_write", {31'd0, mem_write}, 32'd1);
    check("wr_mem_wa", {23'd0, mem_wa}, 32'd5);
    check("wr_mem_d", {12'd0, mem_d}, 32'hABCDE);
    tick;
    we0 = 1'b0;
    #1;
    check("rd_gnt0", {31'd0, gnt0}, 32'd1);
    check("rd_mem_ra", {23'd0, mem_ra}, 32'd5);
    q0.push_back(20'hABCDE);
    tick;
    req0 = 1'b0;
    #1;
    check("rd_rvalid0", {31'd0, rvalid0}, 32'd1);
    tick; #1;
    check("rvalid0_one_cycle", {31'd0, rvalid0}, 32'd0);
    check("rdata0_hold", {12'd0, rdata0}, 32'hABCDE);
    check("idle_mem_write", {31'd0, mem_write}, 32'd0);
    check("idle_mem_ra", {23'd0, mem_ra}, 32'd0);
    check("idle_mem_wa", {23'd0, mem_wa}, 32'd0);
    check("idle_mem_d", {12'd0, mem_d}, 32'd0);
    tick;

    // ---------------- round robin ----------------
    single(0, 1'b1, 9'd1, 20'h11111, '0);
    single(1, 1'b1, 9'd2, 20'h22222, '0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_gnt1", {31'd0, gnt1}, (k % 2 == 0) ? 32'd0 : 32'd1);
      if (gnt0) q0.push_back(20'h11111);
      if (gnt1) q1.push_back(20'h22222);
      tick;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick;

    // ---------------- preload, clear, read back ----------------
    single(0, 1'b1, 9'd7, 20'h12345, '0);
    single(0, 1'b0, 9'd7, '0, 20'h12345);   // its rvalid lands in the clr_start cycle
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    #1;
    watch_clear(0, bc, dp, gb, aok);
    check("clr_busy_cycles", bc, 32'd512);
    check("clr_addr_sweep", {31'd0, aok}, 32'd1);
    check("clr_done_pulse", dp, 32'd1);
    tick; #1;
    check("clr_done_one_cycle", {31'd0, clr_done}, 32'd0);
    tick;
    single(0, 1'b0, 9'd7, '0, 20'h00000);

    // ---------------- req1 waits during clear ----------------
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'd7;
    #1;
    watch_clear(0, bc, dp, gb, aok);
    check("clr2_no_grants", gb, 32'd0);
    check("clr2_busy_cycles", bc, 32'd512);
    check("clr2_done_gnt1", {31'd0, gnt1}, 32'd1);
    check("clr2_done", {31'd0, clr_done}, 32'd1);
    if (gnt1) q1.push_back(20'h00000);
    tick;
    req1 = 1'b0;
    tick;

    // ---------------- clr_start with req0, restart mid-sweep ----------------
    clr_start = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 9'd7;
    #1;
    check("start_blocks_gnt0", {31'd0, gnt0}, 32'd0);
    tick;
    clr_start = 1'b0;
    #1;
    watch_clear(200, bc, dp, gb, aok);
    check("clr3_busy_cycles", bc, 32'd512);
    check("clr3_done_pulse", dp, 32'd1);
    check("clr3_no_grants", gb, 32'd0);
    check("clr3_done_gnt0", {31'd0, gnt0}, 32'd1);
    if (gnt0) q0.push_back(20'h00000);
    tick;
    req0 = 1'b0;
    tick;

    // ---------------- reset mid-clear ----------------
    clr_start = 1'b1;
    tick;
    clr_start = 1'b0;
    #1;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (clr_busy && mem_wa == 9'd99) seen = 1;
      else begin tick; #1; end
    end
    check("reach_addr_99", {31'd0, seen}, 32'd1);
    tick;
    check("at_addr_100", {23'd0, mem_wa}, 32'd100);
    reset = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 9'd7;
    #1;
    check("rst_mid_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mid_gnt0", {31'd0, gnt0}, 32'd0);
    tick;
    reset = 1'b0;
    #1;
    check("rst_mid_clr_busy", {31'd0, clr_busy}, 32'd0);
    check("rst_mid_clr_done", {31'd0, clr_done}, 32'd0);
    check("rst_mid_gnt0_after", {31'd0, gnt0}, 32'd1);
    if (gnt0) q0.push_back(20'h00000);
    tick;
    req0 = 1'b0;
    dp = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (clr_done || clr_busy) dp++;
      tick;
    end
    check("rst_mid_no_done", dp, 32'd0);

    tick; tick;
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits between two client requesters and the 512x20 two-port memory (async read port, sync write port).
- Shares the memory's single read address and single write port between two requesters using round-robin arbitration.
- Returns registered read data to the granted requester.
- Contains a clear engine that sweeps every address with a fixed value, with priority over both requesters.

Parameters:
- AW, 9, address width; depth = 2**AW.
- DW, 20, data width.
- CLR_VALUE, 0, word written to every address by the clear engine (DW bits).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- clr_start  input  1  request a full-memory clear.
- clr_busy  output  1  clear sweep in progress.
- clr_done  output  1  one-cycle pulse after the final clear write.
- req0, req1  input  1  requester N access request; held until granted.
- we0, we1  input  1  1 = write, 0 = read, for requester N.
- addr0, addr1  input  AW  requester N address.
- wdata0, wdata1  input  DW  requester N write data.
- gnt0, gnt1  output  1  combinational grant; the access happens in this cycle.
- rvalid0, rvalid1  output  1  read data valid, one cycle after a read grant.
- rdata0, rdata1  output  DW  registered read data for requester N.
- mem_ra  output  AW  to memory read address.
- mem_wa  output  AW  to memory write address.
- mem_write  output  1  to memory write enable.
- mem_d  output  DW  to memory write data.
- mem_q  input  DW  from memory async read data.

Behaviour:
- Reset (reset=1 at a clock edge):
  - State goes to IDLE, clr_addr=0, last_grant=1 (requester 0 wins the first tie).
  - Registered outputs clear: rvalid0/1=0, rdata0/1=0, clr_busy=0, clr_done=0.
  - While reset is high, gnt0/1=0 and mem_write=0.
  - Reset mid-clear aborts the sweep immediately; no clr_done pulse.
- States: IDLE, CLEAR.
- IDLE arbitration, one grant per cycle:
  - Only req0: gnt0. Only req1: gnt1.
  - Both: grant the one not equal to last_grant.
  - last_grant updates to the granted index on each grant.
- Granted write:
  - mem_write=1, mem_wa=addrN, mem_d=wdataN in the same cycle.
  - Write visible to a read in the following cycle.
- Granted read:
  - mem_ra=addrN; mem_q is captured into rdataN at that edge.
  - rvalidN=1 for exactly the next cycle; rdataN holds its value until the next read by N.
- Idle defaults: with no grant and not clearing, mem_write=0, mem_ra=0, mem_wa=0, mem_d=0.
- IDLE -> CLEAR:
  - clr_start=1 in IDLE suppresses all grants in that cycle.
  - Next cycle: CLEAR, clr_busy=1, clr_addr=0.
- CLEAR:
  - Each cycle: mem_write=1, mem_wa=clr_addr, mem_d=CLR_VALUE, then clr_addr increments.
  - No grants; pending requests wait holding req.
  - clr_start is ignored.
  - Exactly 2**AW write cycles (addresses 0..511).
- CLEAR -> IDLE:
  - After the write to address 2**AW-1, the next cycle is IDLE, clr_busy=0, clr_done=1 for one cycle.
  - Arbitration resumes in that same cycle.
  - clr_addr wraps to 0 with no carry-out.
- A read in flight (granted in the cycle before clr_start) still completes its rvalid.
- The same requester may be granted on consecutive cycles if the other is not requesting.

Test Plan:
- Reset, req0 write addr0=5 wdata0=20'hABCDE, then req0 read addr0=5 -> gnt0 in each cycle, mem_write=1 with mem_wa=5 in the first cycle, rvalid0=1 and rdata0=20'hABCDE two cycles after the write grant.
- req0 and req1 held high for 4 cycles (both reads, addr 1/2) -> grants alternate 0,1,0,1; rvalid alternates accordingly, never both high.
- Preload addr 7=20'h12345, assert clr_start one cycle -> clr_busy high for exactly 512 cycles, mem_wa steps 0..511, clr_done pulses once; read addr 7 afterward returns 20'h00000.
- req1 asserted during CLEAR -> gnt1 stays 0 until the clr_done cycle, then gnt1=1 in that same cycle.
- clr_start and req0 asserted together in IDLE -> no gnt0 that cycle; clear proceeds; second clr_start mid-sweep has no effect (still 512 cycles).
- Assert reset at clear address 100 -> next cycle clr_busy=0, no clr_done, gnt0 issued to a pending req0 after reset deasserts.
